// File: rtl/modulo_controlador_reposicao_rolhas_if.sv
// Cork storage controller bus: operator/sealer requests in,
// buffer counts and status out.
interface modulo_controlador_reposicao_rolhas_if #(
  parameter int LARGURA = 7
) ();
  logic               en;
  logic               consome;
  logic               carga_req;
  logic [LARGURA-1:0] carga_qtd;
  logic               carga_ack;
  logic               carga_erro;
  logic [LARGURA-1:0] buffer_principal;
  logic [LARGURA-1:0] buffer_secundario;
  logic               transferindo;
  logic               ro;
  logic               min_signal;
  logic               falta;
  logic [1:0]         estado;

  modport master (
    output en,
    output consome,
    output carga_req,
    output carga_qtd,
    input  carga_ack,
    input  carga_erro,
    input  buffer_principal,
    input  buffer_secundario,
    input  transferindo,
    input  ro,
    input  min_signal,
    input  falta,
    input  estado
  );

  modport slave (
    input  en,
    input  consome,
    input  carga_req,
    input  carga_qtd,
    output carga_ack,
    output carga_erro,
    output buffer_principal,
    output buffer_secundario,
    output transferindo,
    output ro,
    output min_signal,
    output falta,
    output estado
  );
endinterface

// File: rtl/modulo_controlador_reposicao_rolhas.sv
// Cork storage sequencer: operator loads into the secondary reservoir,
// batch transfers to the principal buffer, per-bottle consumption.
module modulo_controlador_reposicao_rolhas #(
  parameter int LARGURA    = 7,
  parameter int MAX_ROLHAS = 99,
  parameter int MIN_ROLHAS = 5,
  parameter int LOTE       = 15
) (
  input  logic clk,
  input  logic clr,
  modulo_controlador_reposicao_rolhas_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_CARGA  = 2'b01,
    S_TRANSF = 2'b10,
    S_ILEGAL = 2'b11
  } estado_t;

  localparam logic [LARGURA-1:0] P_MAX  = LARGURA'(MAX_ROLHAS);
  localparam logic [LARGURA-1:0] P_MIN  = LARGURA'(MIN_ROLHAS);
  localparam logic [LARGURA-1:0] P_LOTE = LARGURA'(LOTE);
  localparam logic [LARGURA-1:0] P_UM   = LARGURA'(1);
  localparam logic [LARGURA:0]   P_MAXE = (LARGURA+1)'(MAX_ROLHAS);

  estado_t            r_est;
  logic [LARGURA-1:0] r_prin;
  logic [LARGURA-1:0] r_sec;
  logic [LARGURA-1:0] r_cnt;
  logic [LARGURA-1:0] r_qtd;
  logic               r_ack;
  logic               r_erro;
  logic               r_falta;

  logic               w_move;
  logic               w_ro;
  logic               w_min;
  logic               w_sai;
  logic [LARGURA:0]   w_soma;

  assign w_move = (r_est == S_TRANSF);
  assign w_ro   = (r_prin == '0);
  assign w_min  = (r_prin < P_MIN);
  assign w_soma = {1'b0, r_sec} + {1'b0, bus.carga_qtd};

  // Exit on the edge whose move reaches a limit, or when en drops.
  assign w_sai = !bus.en
              || (r_cnt + P_UM == P_LOTE)
              || (r_sec == P_UM)
              || (r_prin + P_UM == P_MAX);

  assign bus.carga_ack         = r_ack;
  assign bus.carga_erro        = r_erro;
  assign bus.buffer_principal  = r_prin;
  assign bus.buffer_secundario = r_sec;
  assign bus.transferindo      = w_move;
  assign bus.ro                = w_ro;
  assign bus.min_signal        = w_min;
  assign bus.falta             = r_falta;
  assign bus.estado            = r_est;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_est   <= S_IDLE;
      r_prin  <= '0;
      r_sec   <= '0;
      r_cnt   <= '0;
      r_qtd   <= '0;
      r_ack   <= 1'b0;
      r_erro  <= 1'b0;
      r_falta <= 1'b0;
    end else begin
      r_ack   <= 1'b0;
      r_erro  <= 1'b0;
      r_falta <= bus.consome && w_ro && !w_move;

      // A move and a consumption in the same cycle cancel out.
      if (w_move && !bus.consome) begin
        r_prin <= r_prin + P_UM;
      end else if (!w_move && bus.consome && !w_ro) begin
        r_prin <= r_prin - P_UM;
      end

      unique case (r_est)
        S_IDLE: begin
          if (bus.carga_req) begin
            r_est  <= S_CARGA;
            r_qtd  <= bus.carga_qtd;
            r_ack  <= 1'b1;
            r_erro <= (w_soma > P_MAXE);
          end else if (bus.en && w_min && r_sec != '0) begin
            r_est <= S_TRANSF;
            r_cnt <= '0;
          end
        end
        S_CARGA: begin
          if (!r_erro) begin
            r_sec <= r_sec + r_qtd;
          end
          r_est <= S_IDLE;
        end
        S_TRANSF: begin
          r_sec <= r_sec - P_UM;
          r_cnt <= r_cnt + P_UM;
          if (w_sai) begin
            r_est <= S_IDLE;
          end
        end
        S_ILEGAL: begin
          r_est <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_modulo_controlador_reposicao_rolhas.sv
// Bench for the cork storage sequencer: directed scenarios plus random
// traffic against a transaction-level reference model and scoreboard.
module tb_modulo_controlador_reposicao_rolhas;

  localparam int MAXR = 99;
  localparam int MINR = 5;
  localparam int LOTE = 15;

  logic clk = 1'b0;
  logic clr;

  always #5 clk = ~clk;

  modulo_controlador_reposicao_rolhas_if bus ();

  modulo_controlador_reposicao_rolhas dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  bit mon_on = 1'b0;

  // Reference model: mode 0 idle, 1 load, 2 transfer.
  int m_mode = 0;
  int m_prin = 0;
  int m_sec  = 0;
  int m_left = 0;
  int m_qtd  = 0;
  bit m_erro = 1'b0;
  bit m_falta = 1'b0;
  int p0;
  bit moving;

  bit q_ack[$];
  int q_falta[$];

  function automatic void chk(input string nm, input int act,
                              input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endfunction

  function automatic int min3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b < m) m = b;
    if (c < m) m = c;
    return m;
  endfunction

  always @(posedge clk) begin
    if (clr) begin
      m_mode = 0;
      m_prin = 0;
      m_sec  = 0;
      m_left = 0;
      m_erro = 1'b0;
      m_falta = 1'b0;
      q_ack.delete();
      q_falta.delete();
    end else begin
      p0 = m_prin;
      moving = (m_mode == 2);
      m_falta = 1'b0;
      case (m_mode)
        0: begin
          if (bus.carga_req) begin
            m_qtd  = int'(bus.carga_qtd);
            m_erro = (m_sec + m_qtd > MAXR);
            q_ack.push_back(m_erro);
            m_mode = 1;
          end else if (bus.en && m_prin < MINR && m_sec > 0) begin
            m_left = min3(LOTE, m_sec, MAXR - m_prin);
            m_mode = 2;
          end
        end
        1: begin
          if (!m_erro) m_sec = m_sec + m_qtd;
          m_mode = 0;
        end
        2: begin
          m_sec  = m_sec - 1;
          m_left = m_left - 1;
          if (m_left == 0 || !bus.en) m_mode = 0;
        end
        default: m_mode = 0;
      endcase
      if (bus.consome) begin
        if (!moving) begin
          if (p0 > 0) begin
            m_prin = p0 - 1;
          end else begin
            m_falta = 1'b1;
            q_falta.push_back(0);
          end
        end
      end else if (moving) begin
        m_prin = p0 + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (mon_on) begin
      chk("principal", int'(bus.buffer_principal), m_prin);
      chk("secundario", int'(bus.buffer_secundario), m_sec);
      chk("estado", int'(bus.estado), m_mode);
      chk("transferindo", int'(bus.transferindo), int'(m_mode == 2));
      chk("ro", int'(bus.ro), int'(m_prin == 0));
      chk("min_signal", int'(bus.min_signal), int'(m_prin < MINR));
      chk("falta", int'(bus.falta), int'(m_falta));
      if (bus.carga_ack) begin
        if (q_ack.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL ack_unexpected: got 1 expected 0 at %0t", $time);
        end else begin
          chk("carga_erro", int'(bus.carga_erro), int'(q_ack.pop_front()));
        end
      end else begin
        chk("erro_sem_ack", int'(bus.carga_erro), 0);
      end
      if (bus.falta) begin
        if (q_falta.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL falta_unexpected: got 1 expected 0 at %0t", $time);
        end else begin
          chk("falta_prin", int'(bus.buffer_principal), q_falta.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic reset_dut();
    clr = 1'b1;
    bus.en = 1'b0;
    bus.consome = 1'b0;
    bus.carga_req = 1'b0;
    bus.carga_qtd = '0;
    repeat (2) @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic carga(input int q, output bit erro);
    int n;
    n = 0;
    bus.carga_qtd = 7'(q);
    bus.carga_req = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.carga_ack && n < 60);
    chk("ack_timeout", int'(bus.carga_ack), 1);
    erro = bus.carga_erro;
    bus.carga_req = 1'b0;
  endtask

  task automatic espera_inicio();
    int k;
    k = 0;
    while (!bus.transferindo && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("transf_start_timeout", int'(bus.transferindo), 1);
  endtask

  task automatic espera_transf(output int n);
    int k;
    k = 0;
    n = 0;
    while (!bus.transferindo && k < 20) begin
      @(negedge clk);
      k++;
    end
    while (bus.transferindo && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    bit e;
    int n;
    int pend;

    reset_dut();
    mon_on = 1'b1;
    chk("rst_estado", int'(bus.estado), 0);
    chk("rst_prin", int'(bus.buffer_principal), 0);
    chk("rst_sec", int'(bus.buffer_secundario), 0);
    chk("rst_ro", int'(bus.ro), 1);
    chk("rst_min", int'(bus.min_signal), 1);
    chk("rst_ack", int'(bus.carga_ack), 0);

    // Load 40 then an automatic 15-cork batch
    bus.en = 1'b1;
    carga(40, e);
    chk("t1_erro", int'(e), 0);
    espera_transf(n);
    chk("t1_ciclos", n, 15);
    chk("t1_prin", int'(bus.buffer_principal), 15);
    chk("t1_sec", int'(bus.buffer_secundario), 25);
    chk("t1_ro", int'(bus.ro), 0);
    chk("t1_min", int'(bus.min_signal), 0);

    // Overflowing load is rejected, exact fit to 99 is accepted
    reset_dut();
    carga(90, e);
    tick();
    chk("t2_sec90", int'(bus.buffer_secundario), 90);
    carga(10, e);
    chk("t2_erro", int'(e), 1);
    tick();
    chk("t2_sec_keep", int'(bus.buffer_secundario), 90);
    carga(9, e);
    chk("t2_erro99", int'(e), 0);
    tick();
    chk("t2_sec99", int'(bus.buffer_secundario), 99);

    // Transfer limited by an emptying reservoir
    reset_dut();
    carga(7, e);
    bus.en = 1'b1;
    espera_transf(n);
    chk("t3a_ciclos", n, 7);
    bus.en = 1'b0;
    bus.consome = 1'b1;
    repeat (3) tick();
    bus.consome = 1'b0;
    chk("t3_prin4", int'(bus.buffer_principal), 4);
    carga(3, e);
    tick();
    chk("t3_sec3", int'(bus.buffer_secundario), 3);
    bus.en = 1'b1;
    espera_transf(n);
    chk("t3_ciclos", n, 3);
    chk("t3_prin", int'(bus.buffer_principal), 7);
    chk("t3_sec", int'(bus.buffer_secundario), 0);

    // Consumption during a transfer cancels the principal increment
    reset_dut();
    carga(40, e);
    tick();
    bus.en = 1'b1;
    espera_inicio();
    n = 1;
    bus.consome = 1'b1;
    repeat (5) begin
      tick();
      if (bus.transferindo) n++;
    end
    bus.consome = 1'b0;
    chk("t4_prin_mid", int'(bus.buffer_principal), 0);
    chk("t4_sec_mid", int'(bus.buffer_secundario), 35);
    while (bus.transferindo && n < 100) begin
      tick();
      if (bus.transferindo) n++;
    end
    chk("t4_ciclos", n, 15);
    chk("t4_prin", int'(bus.buffer_principal), 10);
    chk("t4_sec", int'(bus.buffer_secundario), 25);

    // Consumption on an empty principal buffer
    reset_dut();
    bus.consome = 1'b1;
    tick();
    bus.consome = 1'b0;
    chk("t5_falta", int'(bus.falta), 1);
    chk("t5_prin", int'(bus.buffer_principal), 0);
    chk("t5_ro", int'(bus.ro), 1);
    tick();
    chk("t5_falta_pulse", int'(bus.falta), 0);

    // Reset in the middle of a transfer
    reset_dut();
    carga(40, e);
    tick();
    bus.en = 1'b1;
    espera_inicio();
    repeat (3) tick();
    clr = 1'b1;
    tick();
    chk("t6_estado", int'(bus.estado), 0);
    chk("t6_prin", int'(bus.buffer_principal), 0);
    chk("t6_sec", int'(bus.buffer_secundario), 0);
    chk("t6_transf", int'(bus.transferindo), 0);
    clr = 1'b0;

    // Random traffic
    pend = 0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (bus.carga_req) begin
        pend++;
        if (bus.carga_ack) begin
          bus.carga_req = 1'b0;
          pend = 0;
        end else if (pend > 60) begin
          chk("rnd_ack_timeout", pend, 0);
          bus.carga_req = 1'b0;
          pend = 0;
        end
      end else if ($urandom_range(0, 19) == 0) begin
        bus.carga_req = 1'b1;
        bus.carga_qtd = 7'($urandom_range(0, 70));
      end
      bus.en = ($urandom_range(0, 9) != 0);
      bus.consome = ($urandom_range(0, 3) == 0);
    end
    bus.consome = 1'b0;
    bus.en = 1'b0;
    if (bus.carga_req) begin
      pend = 0;
      while (!bus.carga_ack && pend < 60) begin
        tick();
        pend++;
      end
      chk("fim_ack", int'(bus.carga_ack), 1);
      bus.carga_req = 1'b0;
    end
    repeat (20) tick();
    chk("fim_fila_ack", q_ack.size(), 0);
    chk("fim_fila_falta", q_falta.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
